// File: rtl/ldtu_enc_pkg.sv
// Shared constants, packer state type and slot-insert helper for the LDTU sample encoder.
package ldtu_enc_pkg;

  localparam int SAMPLE_W = 13;
  localparam int BASE_W   = 6;
  localparam int WORD_W   = 32;

  localparam logic [1:0] HDR_BASE_FULL  = 2'b01;
  localparam logic [3:0] HDR_BASE_PART  = 4'b1101;
  localparam logic [5:0] HDR_SIG_PAIR   = 6'b001010;
  localparam logic [5:0] HDR_SIG_SINGLE = 6'b001011;
  localparam logic [3:0] HDR_TRAILER    = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BASE = 2'd1,
    SIG  = 2'd2
  } pk_state_e;

  // Place a 6-bit baseline payload into slot 0..3 of the 24-bit accumulation buffer.
  function automatic logic [23:0] base_insert(input logic [23:0] cur,
                                              input logic [2:0] slot,
                                              input logic [BASE_W-1:0] s);
    logic [23:0] r;
    r = cur;
    case (slot)
      3'd0:    r[5:0]   = s;
      3'd1:    r[11:6]  = s;
      3'd2:    r[17:12] = s;
      default: r[23:18] = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ldtu_enc_ofifo.sv
// Show-ahead synchronous FIFO, one push and one pop per cycle; reads 0 when empty.
module ldtu_enc_ofifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ldtu_sample_encoder.sv
// Packs baseline/signal samples into 32-bit words and queues them for the serializer.
// Optional frame trailer words are enabled with the ENC_FRAME_TRAILER_EN macro.
module ldtu_sample_encoder
  import ldtu_enc_pkg::*;
#(
  parameter int OUT_FIFO_DEPTH = 8,
  parameter int FRAME_WORDS    = 64
) (
  input  logic                              CLK,
  input  logic                              reset,
  input  logic [SAMPLE_W-1:0]               DATA_to_enc,
  input  logic                              baseline_flag,
  input  logic                              data_valid,
  output logic [WORD_W-1:0]                 DATA_32,
  output logic                              word_valid,
  input  logic                              word_ready,
  output logic                              fifo_overflow,
  output logic [$clog2(OUT_FIFO_DEPTH):0]   fifo_level
);

  if (OUT_FIFO_DEPTH < 4 || FRAME_WORDS < 1 || FRAME_WORDS > 1023) begin : g_bad_param
    $error("ldtu_sample_encoder: parameter out of range");
  end

  pk_state_e           state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [23:0]         base_q, base_d;
  logic [SAMPLE_W-1:0] sig_q, sig_d;
  logic                ovf_q, ovf_d;

  logic                data_push;
  logic [WORD_W-1:0]   data_word;
  logic                fifo_push;
  logic [WORD_W-1:0]   fifo_wdata;
  logic                fifo_pop, fifo_full, fifo_empty;
  logic [BASE_W-1:0]   bsamp;

  assign bsamp = DATA_to_enc[BASE_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    sig_d     = sig_q;
    data_push = 1'b0;
    data_word = '0;
    if (data_valid) begin
      case (state_q)
        IDLE: begin
          if (baseline_flag) begin
            base_d  = {18'd0, bsamp};
            cnt_d   = 3'd1;
            state_d = BASE;
          end else begin
            sig_d   = DATA_to_enc;
            state_d = SIG;
          end
        end
        BASE: begin
          if (baseline_flag) begin
            if (cnt_q == 3'd4) begin
              data_push = 1'b1;
              data_word = {HDR_BASE_FULL, bsamp, base_q};
              base_d    = '0;
              cnt_d     = 3'd0;
              state_d   = IDLE;
            end else begin
              base_d = base_insert(base_q, cnt_q, bsamp);
              cnt_d  = cnt_q + 3'd1;
            end
          end else begin
            data_push = 1'b1;
            data_word = {HDR_BASE_PART, 1'b0, cnt_q, base_q};
            base_d    = '0;
            cnt_d     = 3'd0;
            sig_d     = DATA_to_enc;
            state_d   = SIG;
          end
        end
        SIG: begin
          data_push = 1'b1;
          if (baseline_flag) begin
            data_word = {HDR_SIG_SINGLE, 13'd0, sig_q};
            base_d    = {18'd0, bsamp};
            cnt_d     = 3'd1;
            state_d   = BASE;
          end else begin
            data_word = {HDR_SIG_PAIR, DATA_to_enc, sig_q};
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef ENC_FRAME_TRAILER_EN
  localparam int FCW = $clog2(FRAME_WORDS + 1);

  logic [FCW-1:0] wcnt_q, wcnt_d;
  logic [7:0]     fnum_q, fnum_d;
  logic           pend_q, pend_d;
  logic           data_ok;

  // Trailers only use cycles without a data word; a dropped trailer still advances the frame number.
  always_comb begin
    wcnt_d     = wcnt_q;
    fnum_d     = fnum_q;
    pend_d     = pend_q;
    fifo_push  = data_push;
    fifo_wdata = data_word;
    data_ok    = data_push && (!fifo_full || fifo_pop);
    if (data_ok) begin
      if (wcnt_q == FCW'(FRAME_WORDS - 1)) begin
        wcnt_d = '0;
        pend_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + FCW'(1);
      end
    end else if (!data_push && pend_q) begin
      fifo_push  = 1'b1;
      fifo_wdata = {HDR_TRAILER, fnum_q, 20'd0};
      pend_d     = 1'b0;
      fnum_d     = fnum_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wcnt_q <= '0;
      fnum_q <= '0;
      pend_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      fnum_q <= fnum_d;
      pend_q <= pend_d;
    end
  end
`else
  assign fifo_push  = data_push;
  assign fifo_wdata = data_word;
`endif

  assign word_valid    = !fifo_empty;
  assign fifo_pop      = word_valid && word_ready;
  assign fifo_overflow = ovf_q;

  always_comb begin
    ovf_d = ovf_q | (fifo_push && fifo_full && !fifo_pop);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      sig_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      sig_q   <= sig_d;
      ovf_q   <= ovf_d;
    end
  end

  ldtu_enc_ofifo #(
    .DEPTH (OUT_FIFO_DEPTH),
    .W     (WORD_W)
  ) u_ofifo (
    .clk   (CLK),
    .rst   (reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (DATA_32),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_ldtu_sample_encoder.sv
// Self-checking bench for ldtu_sample_encoder: vector table, directed corner cases, random vs queue model.
module tb_ldtu_sample_encoder;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int FW    = 2;
`ifdef ENC_FRAME_TRAILER_EN
  localparam bit TRL_ON = 1'b1;
`else
  localparam bit TRL_ON = 1'b0;
`endif

  logic          CLK;
  logic          reset;
  logic [12:0]   DATA_to_enc;
  logic          baseline_flag;
  logic          data_valid;
  logic [31:0]   DATA_32;
  logic          word_valid;
  logic          word_ready;
  logic          fifo_overflow;
  logic [LW-1:0] fifo_level;

  ldtu_sample_encoder #(
    .OUT_FIFO_DEPTH (DEPTH),
    .FRAME_WORDS    (FW)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .DATA_to_enc   (DATA_to_enc),
    .baseline_flag (baseline_flag),
    .data_valid    (data_valid),
    .DATA_32       (DATA_32),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .fifo_overflow (fifo_overflow),
    .fifo_level    (fifo_level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit dv, input bit bf, input logic [12:0] d, input bit rdy);
    @(negedge CLK);
    data_valid    = dv;
    baseline_flag = bf;
    DATA_to_enc   = d;
    word_ready    = rdy;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- reference model: sample groups and a word queue ----------------
  logic [31:0] mq[$];
  logic [12:0] grp[$];
  bit          grp_bf;
  bit          m_ovf;
  bit          m_pend;
  int          m_wc;
  int          m_fn;

  task automatic model_reset();
    mq.delete();
    grp.delete();
    grp_bf = 1'b0;
    m_ovf  = 1'b0;
    m_pend = 1'b0;
    m_wc   = 0;
    m_fn   = 0;
  endtask

  function automatic logic [31:0] flush_grp();
    logic [31:0] w;
    logic [31:0] acc;
    acc = 32'd0;
    if (grp_bf) begin
      foreach (grp[i]) acc = acc + (32'(grp[i][5:0]) << (6 * i));
      if (grp.size() == 5) w = 32'h4000_0000 | acc;
      else                 w = 32'hD000_0000 | (32'(grp.size()) << 24) | acc;
    end else begin
      if (grp.size() == 2) w = 32'h2800_0000 | (32'(grp[1]) << 13) | 32'(grp[0]);
      else                 w = 32'h2C00_0000 | 32'(grp[0]);
    end
    grp.delete();
    return w;
  endfunction

  task automatic model_step(input bit dv, input bit bf, input logic [12:0] d, input bit rdy);
    bit          pop;
    bit          have;
    logic [31:0] w;
    pop  = (mq.size() != 0) && rdy;
    have = 1'b0;
    w    = 32'd0;
    if (dv) begin
      if (grp.size() != 0 && grp_bf != bf) begin
        w    = flush_grp();
        have = 1'b1;
      end
      grp.push_back(d);
      grp_bf = bf;
      if ((bf && grp.size() == 5) || (!bf && grp.size() == 2)) begin
        w    = flush_grp();
        have = 1'b1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (have) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(w);
        if (TRL_ON) begin
          m_wc++;
          if (m_wc == FW) begin
            m_wc   = 0;
            m_pend = 1'b1;
          end
        end
      end else begin
        m_ovf = 1'b1;
      end
    end else if (TRL_ON && m_pend) begin
      if (mq.size() < DEPTH) mq.push_back(32'hE000_0000 | (32'(m_fn % 256) << 20));
      else                   m_ovf = 1'b1;
      m_pend = 1'b0;
      m_fn++;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset      = 1'b1;
    data_valid = 1'b0;
    word_ready = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    bit          dv;
    bit          bf;
    logic [12:0] d;
    bit          rdy;
    bit          ev;
    logic [31:0] ed;
    int          el;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input bit r, input bit dv, input bit bf, input logic [12:0] d,
                      input bit rdy, input bit ev, input logic [31:0] ed, input int el);
    vec_t v;
    v.rst = r; v.dv = dv; v.bf = bf; v.d = d; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el;
    vecs.push_back(v);
  endtask

  logic [31:0] w4[8];
  logic [31:0] w6[6];

  initial begin
    reset         = 1'b0;
    DATA_to_enc   = '0;
    baseline_flag = 1'b0;
    data_valid    = 1'b0;
    word_ready    = 1'b0;
    model_reset();

    w4 = '{32'hD100_0000, 32'h2C00_0101, 32'hD100_0002, 32'h2C00_0103,
           32'hD100_0004, 32'h2C00_0105, 32'hD100_0006, 32'h2C00_0107};
    w6 = '{32'h2820_2100, 32'h2820_6102, 32'hE000_0000,
           32'h2820_A104, 32'h2820_E106, 32'hE010_0000};

    // five baselines (upper bits of the first sample must be ignored)
    addv(1, 0, 0, 13'h0000, 1, 0, 32'h0, 0);
    addv(0, 1, 1, 13'h1FC1, 1, 0, 32'h0, 0);
    addv(0, 1, 1, 13'h0002, 1, 0, 32'h0, 0);
    addv(0, 1, 1, 13'h0003, 1, 0, 32'h0, 0);
    addv(0, 1, 1, 13'h0004, 1, 0, 32'h0, 0);
    addv(0, 1, 1, 13'h0005, 1, 1, 32'h4510_3081, 1);
    addv(0, 0, 0, 13'h0000, 1, 0, 32'h0, 0);
    // signal pair
    addv(1, 0, 0, 13'h0000, 1, 0, 32'h0, 0);
    addv(0, 1, 0, 13'h1ABC, 1, 0, 32'h0, 0);
    addv(0, 1, 0, 13'h0123, 1, 1, 32'h2824_7ABC, 1);
    addv(0, 0, 0, 13'h0000, 1, 0, 32'h0, 0);
    // partial baseline, single signal, then packer continues in BASE with one sample
    addv(1, 0, 0, 13'h0000, 1, 0, 32'h0, 0);
    addv(0, 1, 1, 13'h0007, 1, 0, 32'h0, 0);
    addv(0, 1, 1, 13'h0008, 1, 0, 32'h0, 0);
    addv(0, 1, 1, 13'h0009, 1, 0, 32'h0, 0);
    addv(0, 1, 0, 13'h1000, 1, 1, 32'hD300_9207, 1);
    addv(0, 1, 1, 13'h0005, 1, 1, 32'h2C00_1000, 1);
    addv(0, 0, 0, 13'h0000, 1, TRL_ON, TRL_ON ? 32'hE000_0000 : 32'h0, TRL_ON ? 1 : 0);
    addv(0, 1, 1, 13'h0001, 1, 0, 32'h0, 0);
    addv(0, 1, 1, 13'h0002, 1, 0, 32'h0, 0);
    addv(0, 1, 1, 13'h0003, 1, 0, 32'h0, 0);
    addv(0, 1, 1, 13'h0004, 1, 1, 32'h440C_2045, 1);
    addv(0, 0, 0, 13'h0000, 1, 0, 32'h0, 0);

    do_reset();
    #1;
    chk("reset_state", {word_valid, DATA_32, fifo_level, fifo_overflow}, '0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        do_reset();
      end else begin
        drive(vecs[i].dv, vecs[i].bf, vecs[i].d, vecs[i].rdy);
        chk($sformatf("vec%0d", i), {word_valid, DATA_32, fifo_level},
            {vecs[i].ev, vecs[i].ed, LW'(vecs[i].el)});
      end
    end

    // overflow with a stalled consumer, then drain in order
    do_reset();
    for (int k = 0; k < 10; k++)
      drive(1'b1, (k % 2) == 0, ((k % 2) == 0) ? 13'(k) : 13'(32'h100 + k), 1'b0);
    drive(1'b0, 1'b0, 13'h0, 1'b0);
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk("ovf_flag", 64'(fifo_overflow), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), {word_valid, DATA_32}, {1'b1, w4[i]});
      drive(1'b0, 1'b0, 13'h0, 1'b1);
    end
    chk("drain_empty", {word_valid, DATA_32, fifo_level}, '0);
    chk("ovf_sticky", 64'(fifo_overflow), 64'd1);

    // asynchronous reset mid-cycle with a word queued and two baselines pending
    do_reset();
    drive(1'b1, 1'b0, 13'h0AAA, 1'b0);
    drive(1'b1, 1'b0, 13'h0555, 1'b0);
    drive(1'b1, 1'b1, 13'h000B, 1'b0);
    drive(1'b1, 1'b1, 13'h0016, 1'b0);
    chk("pre_areset", {word_valid, fifo_level}, {1'b1, LW'(1)});
    @(negedge CLK);
    data_valid = 1'b0;
    @(posedge CLK);
    #3 reset = 1'b1;
    #1;
    chk("areset_now", {word_valid, DATA_32, fifo_level, fifo_overflow}, '0);
    @(negedge CLK);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b1, 13'(k), 1'b1);
      chk($sformatf("no_stale%0d", k), 64'(word_valid), 64'd0);
    end
    drive(1'b1, 1'b1, 13'h0005, 1'b1);
    chk("after_areset", {word_valid, DATA_32}, {1'b1, 32'h4510_3081});

`ifdef ENC_FRAME_TRAILER_EN
    do_reset();
    for (int p = 0; p < 4; p++) begin
      drive(1'b1, 1'b0, 13'(32'h100 + 2 * p), 1'b0);
      drive(1'b1, 1'b0, 13'(32'h101 + 2 * p), 1'b0);
    end
    drive(1'b0, 1'b0, 13'h0, 1'b0);
    chk("trl_level", 64'(fifo_level), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("trl%0d", i), {word_valid, DATA_32}, {1'b1, w6[i]});
      drive(1'b0, 1'b0, 13'h0, 1'b1);
    end
`endif

    // random stimulus against the queue model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit          dv;
      bit          bf;
      bit          rdy;
      logic [12:0] d;
      logic [31:0] ed;
      dv  = ($urandom_range(0, 3) != 0);
      bf  = ($urandom_range(0, 1) != 0);
      d   = 13'($urandom);
      rdy = (n < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      model_step(dv, bf, d, rdy);
      drive(dv, bf, d, rdy);
      ed = (mq.size() != 0) ? mq[0] : 32'd0;
      chk($sformatf("rand%0d", n), {word_valid, fifo_overflow, fifo_level, DATA_32},
          {mq.size() != 0, m_ovf, LW'(mq.size()), ed});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
